// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 16-state encoding, data-register select and IR capture pattern.
package jtag_tap_pkg;

  typedef logic [3:0] tap_state_t;

  // Numbering matches the legacy FSM so state dumps stay comparable.
  localparam logic [3:0] TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] SELECT_DR_SCAN   = 4'd2;
  localparam logic [3:0] CAPTURE_DR       = 4'd3;
  localparam logic [3:0] SHIFT_DR         = 4'd4;
  localparam logic [3:0] EXIT1_DR         = 4'd5;
  localparam logic [3:0] PAUSE_DR         = 4'd6;
  localparam logic [3:0] EXIT2_DR         = 4'd7;
  localparam logic [3:0] UPDATE_DR        = 4'd8;
  localparam logic [3:0] SELECT_IR_SCAN   = 4'd9;
  localparam logic [3:0] CAPTURE_IR       = 4'd10;
  localparam logic [3:0] SHIFT_IR         = 4'd11;
  localparam logic [3:0] EXIT1_IR         = 4'd12;
  localparam logic [3:0] PAUSE_IR         = 4'd13;
  localparam logic [3:0] EXIT2_IR         = 4'd14;
  localparam logic [3:0] UPDATE_IR        = 4'd15;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;
  localparam int         IDCODE_W   = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TMS-driven TAP state register; exports the next state so the datapath can
// react to an entry into TEST_LOGIC_RESET on the same edge.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state,
  output tap_state_t state_next
);

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_next = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_next = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_next = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP: instruction register, BYPASS/USER (and optional IDCODE) data registers, TDO path.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register and make it the reset instruction.
module jtag_tap_controller
  import jtag_tap_pkg::*;
#(
  parameter int              IR_W      = 4,
  parameter int              UDR_W     = 8,
  parameter logic [31:0]     IDCODE    = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(1),
  parameter logic [IR_W-1:0] OP_USER   = IR_W'(2)
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_EN,
  output tap_state_t       state,
  output logic [IR_W-1:0]  ir,
  input  logic [UDR_W-1:0] udr_capture,
  output logic [UDR_W-1:0] udr_update,
  output logic             udr_valid
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET = '1;
`endif
  localparam logic [IR_W-1:0] IR_CAPTURE_VAL = IR_W'(IR_CAPTURE);

  if (IDCODE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE bit 0 must be 1");
  end

  tap_state_t       state_next;
  dr_sel_t          dr_sel;
  logic [IR_W-1:0]  ir_sh;
  logic             bypass_sh;
  logic [UDR_W-1:0] user_sh;
  logic [UDR_W:0]   user_cat;
  logic             dr_lsb;
`ifdef JTAG_TAP_IDCODE_EN
  logic [IDCODE_W-1:0] idcode_sh;
`endif

  jtag_tap_fsm u_fsm (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .state      (state),
    .state_next (state_next)
  );

  // All-ones always wins so BYPASS stays reachable whatever the opcode parameters are.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == '1) begin
      dr_sel = DR_BYPASS;
    end else if (ir == OP_USER) begin
      dr_sel = DR_USER;
`ifdef JTAG_TAP_IDCODE_EN
    end else if (ir == OP_IDCODE) begin
      dr_sel = DR_IDCODE;
`else
    end else if (ir == OP_IDCODE) begin
      dr_sel = DR_BYPASS;
`endif
    end
  end

  // Concatenation keeps the shift expression legal when UDR_W is 1.
  assign user_cat = {TDI, user_sh};

  always_comb begin
    dr_lsb = bypass_sh;
    case (dr_sel)
      DR_USER:   dr_lsb = user_sh[0];
`ifdef JTAG_TAP_IDCODE_EN
      DR_IDCODE: dr_lsb = idcode_sh[0];
`endif
      default:   dr_lsb = bypass_sh;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir         <= IR_RESET;
      ir_sh      <= '0;
      bypass_sh  <= 1'b0;
      user_sh    <= '0;
      TDO        <= 1'b0;
      TDO_EN     <= 1'b0;
      udr_update <= '0;
      udr_valid  <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sh  <= '0;
`endif
    end else begin
      TDO_EN    <= (state == SHIFT_IR) || (state == SHIFT_DR);
      udr_valid <= 1'b0;

      if (state_next == TEST_LOGIC_RESET) begin
        ir <= IR_RESET;
      end else if (state == UPDATE_IR) begin
        ir <= ir_sh;
      end

      case (state)
        CAPTURE_IR: ir_sh <= IR_CAPTURE_VAL;
        SHIFT_IR: begin
          TDO   <= ir_sh[0];
          ir_sh <= {TDI, ir_sh[IR_W-1:1]};
        end
        CAPTURE_DR: begin
          case (dr_sel)
            DR_USER:   user_sh   <= udr_capture;
`ifdef JTAG_TAP_IDCODE_EN
            DR_IDCODE: idcode_sh <= IDCODE;
`endif
            default:   bypass_sh <= 1'b0;
          endcase
        end
        SHIFT_DR: begin
          TDO <= dr_lsb;
          case (dr_sel)
            DR_USER:   user_sh   <= user_cat[UDR_W:1];
`ifdef JTAG_TAP_IDCODE_EN
            DR_IDCODE: idcode_sh <= {TDI, idcode_sh[IDCODE_W-1:1]};
`endif
            default:   bypass_sh <= TDI;
          endcase
        end
        UPDATE_DR: begin
          if (dr_sel == DR_USER) begin
            udr_update <= user_sh;
            udr_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomised bench for jtag_tap_controller against a queue-based scan model.
module tb_jtag_tap_controller;

  localparam int              IR_W   = 4;
  localparam int              UDR_W  = 8;
  localparam logic [31:0]     IDC    = 32'h1000_0001;
  localparam logic [IR_W-1:0] OP_ID  = 4'h1;
  localparam logic [IR_W-1:0] OP_US  = 4'h2;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit              ID_EN  = 1'b1;
  localparam logic [IR_W-1:0] IR_RST = OP_ID;
`else
  localparam bit              ID_EN  = 1'b0;
  localparam logic [IR_W-1:0] IR_RST = 4'hF;
`endif

  logic             TCK = 1'b0;
  logic             TRST = 1'b0;
  logic             TMS = 1'b0;
  logic             TDI = 1'b0;
  logic             TDO;
  logic             TDO_EN;
  logic [3:0]       state;
  logic [IR_W-1:0]  ir;
  logic [UDR_W-1:0] udr_capture = '0;
  logic [UDR_W-1:0] udr_update;
  logic             udr_valid;

  jtag_tap_controller #(
    .IR_W(IR_W), .UDR_W(UDR_W), .IDCODE(IDC), .OP_IDCODE(OP_ID), .OP_USER(OP_US)
  ) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .state(state), .ir(ir), .udr_capture(udr_capture), .udr_update(udr_update),
    .udr_valid(udr_valid)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: IEEE 1149.1 transition table plus shift registers held as bit queues.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int               m_state;
  int               m_sel;
  logic [IR_W-1:0]  m_ir;
  logic [UDR_W-1:0] m_udr;
  bit               m_tdo, m_en, m_valid;
  bit               ir_q[$];
  bit               dr_q[$];

  function automatic logic [63:0] pack(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  // 0 bypass, 1 idcode, 2 user
  function automatic int sel_of(input logic [IR_W-1:0] v);
    if (v == 4'hF) return 0;
    if (v == OP_US) return 2;
    if (v == OP_ID && ID_EN) return 1;
    return 0;
  endfunction

  task automatic step(input bit tms, input bit tdi, input bit trst = 1'b0);
    int          n;
    int          len;
    logic [63:0] v;
    TMS  = tms;
    TDI  = tdi;
    TRST = trst;
    @(posedge TCK);
    if (trst) begin
      m_state = 0; m_ir = IR_RST; m_tdo = 0; m_en = 0; m_udr = '0; m_valid = 0; m_sel = 0;
      ir_q.delete();
      dr_q.delete();
    end else begin
      n = tms ? nxt1[m_state] : nxt0[m_state];
      m_valid = 0;
      m_en = (m_state == 11) || (m_state == 4);
      case (m_state)
        10: begin
          ir_q.delete();
          for (int i = 0; i < IR_W; i++) ir_q.push_back(i == 0);
        end
        11: begin m_tdo = ir_q.pop_front(); ir_q.push_back(tdi); end
        15: m_ir = IR_W'(pack(ir_q));
        3: begin
          m_sel = sel_of(m_ir);
          if (m_sel == 2) begin v = 64'(udr_capture); len = UDR_W; end
          else if (m_sel == 1) begin v = 64'(IDC); len = 32; end
          else begin v = '0; len = 1; end
          dr_q.delete();
          for (int i = 0; i < len; i++) dr_q.push_back(v[i]);
        end
        4: begin m_tdo = dr_q.pop_front(); dr_q.push_back(tdi); end
        8: if (m_sel == 2) begin m_udr = UDR_W'(pack(dr_q)); m_valid = 1; end
        default: ;
      endcase
      if (n == 0) m_ir = IR_RST;
      m_state = n;
    end
    #1;
    check("state", 64'(state), 64'(m_state));
    check("ir", 64'(ir), 64'(m_ir));
    check("tdo", 64'(TDO), 64'(m_tdo));
    check("tdo_en", 64'(TDO_EN), 64'(m_en));
    check("udr_update", 64'(udr_update), 64'(m_udr));
    check("udr_valid", 64'(udr_valid), 64'(m_valid));
  endtask

  // From Run-Test/Idle: one IR or DR scan of n bits, optional pause after pause_after bits.
  task automatic scan(input bit is_ir, input logic [63:0] din, input int n,
                      input int pause_after, output logic [63:0] dout);
    bit last;
    dout = '0;
    step(1, 0);
    if (is_ir) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      step(last || (i == pause_after - 1), din[i]);
      dout[i] = TDO;
      if (!last && i == pause_after - 1) begin
        step(0, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end
    end
    step(1, 0);
    step(0, 0);
    $display("scan %s n=%0d pause=%0d din=%0h dout=%0h ir=%0h udr=%0h",
             is_ir ? "IR" : "DR", n, pause_after, din, dout, ir, udr_update);
  endtask

  task automatic to_idle();
    for (int i = 0; i < 5; i++) step(1, 1'($urandom));
    step(0, 0);
  endtask

  initial begin
    logic [63:0]     d;
    logic [IR_W-1:0] op;
    int              n;

    // Reset and first move
    step(0, 0, 1);
    check("rst_state", 64'(state), 64'd0);
    check("rst_ir", 64'(ir), 64'(IR_RST));
    check("rst_tdo_en", 64'(TDO_EN), 64'd0);
    step(0, 0);
    check("rti_state", 64'(state), 64'd1);

    // IDCODE (or bypass) read straight after reset
    scan(0, 64'd0, 32, 0, d);
    check("idcode_stream", d, ID_EN ? 64'(IDC) : 64'd0);

    // IR capture pattern and 1-bit bypass delay
    scan(1, 64'hF, 4, 0, d);
    check("ir_capture", d, 64'b0001);
    check("ir_bypass", 64'(ir), 64'hF);
    scan(0, 64'b101, 3, 0, d);
    check("bypass_stream", d, 64'b010);

    // User register capture/update and valid pulse
    scan(1, 64'(OP_US), 4, 0, d);
    udr_capture = 8'hA5;
    scan(0, 64'h3C, 8, 0, d);
    check("user_stream", d, 64'hA5);
    check("udr_update_val", 64'(udr_update), 64'h3C);
    check("udr_valid_hi", 64'(udr_valid), 64'd1);
    step(0, 0);
    check("udr_valid_lo", 64'(udr_valid), 64'd0);

    // Pause in the middle of a DR scan resumes without recapture
    udr_capture = 8'h5A;
    scan(0, 64'hC3, 8, 3, d);
    check("pause_stream", d, 64'h5A);
    check("pause_udr", 64'(udr_update), 64'hC3);

    // TMS reset mid Shift-IR keeps udr_update
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0);
    check("ir_midscan", 64'(ir), 64'(OP_US));
    for (int i = 0; i < 5; i++) step(1, 0);
    check("tms_rst_state", 64'(state), 64'd0);
    check("tms_rst_ir", 64'(ir), 64'(IR_RST));
    check("tms_rst_udr", 64'(udr_update), 64'hC3);
    step(0, 0);

    // TRST mid Shift-IR discards the partial instruction
    scan(1, 64'(OP_US), 4, 0, d);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1);
    step(0, 0, 1);
    check("trst_mid_ir", 64'(ir), 64'(IR_RST));
    check("trst_mid_state", 64'(state), 64'd0);
    step(0, 0);

    // Five TMS=1 from wherever a random walk lands
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        udr_capture = UDR_W'($urandom);
        step(1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 5; i++) step(1, 1'($urandom));
      check("walk_rst_state", 64'(state), 64'd0);
      check("walk_rst_ir", 64'(ir), 64'(IR_RST));
    end
    step(0, 0);

    // Random mix of scans and walks, checked every cycle against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 3))
            0: op = OP_US;
            1: op = OP_ID;
            2: op = 4'hF;
            default: op = IR_W'($urandom);
          endcase
          n = IR_W + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
          d = {$urandom, $urandom};
          d[IR_W-1:0] = op;
          d = d << (n - IR_W);
          scan(1, d, n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0, d);
        end
        1, 2: begin
          udr_capture = UDR_W'($urandom);
          n = $urandom_range(1, 40);
          scan(0, {$urandom, $urandom}, n,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0, d);
        end
        default: begin
          for (int i = 0; i < 10; i++) begin
            udr_capture = UDR_W'($urandom);
            step(1'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
          end
          to_idle();
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
